vga_timing_gen: RTL



---
 rtl/vga_pkg.sv | 52 +++++
 rtl/vga_axis_counter.sv | 46 ++++
 rtl/vga_timing_gen.sv | 132 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing generator: register map, CTRL bits,
// 640x480 reset timing and packed pixel channel slots.
package vga_pkg;

  localparam int NUM_TIMING = 8;
  localparam int NUM_REGS   = 9;

  localparam int ADDR_H_ACT  = 0;
  localparam int ADDR_H_FP   = 1;
  localparam int ADDR_H_SYNC = 2;
  localparam int ADDR_H_BP   = 3;
  localparam int ADDR_V_ACT  = 4;
  localparam int ADDR_V_FP   = 5;
  localparam int ADDR_V_SYNC = 6;
  localparam int ADDR_V_BP   = 7;
  localparam int ADDR_CTRL   = 8;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_HPOL = 1;
  localparam int CTRL_VPOL = 2;
  localparam int CTRL_TEST = 3;

  localparam int DEF_H_ACT  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_ACT  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;
  localparam int DEF_CTRL   = 1;  // enabled, negative sync polarity

  // Channel slot in the packed pixel; bit offset = slot * COLOR_WIDTH
  localparam int PIX_R = 2;
  localparam int PIX_G = 1;
  localparam int PIX_B = 0;

  function automatic int timing_default(int idx);
    case (idx)
      ADDR_H_ACT:  return DEF_H_ACT;
      ADDR_H_FP:   return DEF_H_FP;
      ADDR_H_SYNC: return DEF_H_SYNC;
      ADDR_H_BP:   return DEF_H_BP;
      ADDR_V_ACT:  return DEF_V_ACT;
      ADDR_V_FP:   return DEF_V_FP;
      ADDR_V_SYNC: return DEF_V_SYNC;
      ADDR_V_BP:   return DEF_V_BP;
      default:     return 0;
    endcase
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: counter with wrap at act+fp+sync+bp-1 plus active and
// sync-window decode of the current count.
module vga_axis_counter #(
  parameter int CNT_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 step,
  input  logic [CNT_WIDTH-1:0] act,
  input  logic [CNT_WIDTH-1:0] fp,
  input  logic [CNT_WIDTH-1:0] sync,
  input  logic [CNT_WIDTH-1:0] bp,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 wrap,
  output logic                 active,
  output logic                 sync_on
);

  // Two guard bits so the sum of four full-scale fields cannot overflow
  localparam int TW = CNT_WIDTH + 2;

  logic [TW-1:0] tot, last, cnt_x, sync_lo, sync_hi;

  // Totals and window decode; a zero total behaves as a one-cycle axis
  always_comb begin
    tot = TW'(act) + TW'(fp) + TW'(sync) + TW'(bp);
    if (tot == '0) tot = TW'(1);
    last    = tot - TW'(1);
    cnt_x   = TW'(count);
    sync_lo = TW'(act) + TW'(fp);
    sync_hi = sync_lo + TW'(sync);
    // >= rather than == keeps the axis self-recovering if it ever overshoots
    wrap    = step && (cnt_x >= last);
    active  = cnt_x < TW'(act);
    sync_on = (cnt_x >= sync_lo) && (cnt_x < sync_hi);
  end

  // Counter: held at 0 while disabled, otherwise advances on step
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count <= '0;
    else if (!en)   count <= '0;
    else if (step)  count <= wrap ? '0 : count + CNT_WIDTH'(1);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator with programmable shadowed timing, sync polarity,
// enable and test pattern. Shadow registers are copied to live at the
// last pixel of a frame, or continuously while live EN is clear.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CNT_WIDTH   = 12,
  parameter int COLOR_WIDTH = 4,
  parameter int DATA_WIDTH  = 3*COLOR_WIDTH,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   c_valid,
  input  logic [ADDR_WIDTH-1:0]  c_addr,
  input  logic [CNT_WIDTH-1:0]   c_data,
  output logic                   c_ready,
  output logic                   c_err,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic                   pix_req,
  output logic [CNT_WIDTH-1:0]   pix_x,
  output logic [CNT_WIDTH-1:0]   pix_y,
  output logic                   frame_start,
  output logic [COLOR_WIDTH-1:0] RED,
  output logic [COLOR_WIDTH-1:0] GREEN,
  output logic [COLOR_WIDTH-1:0] BLUE,
  output logic                   HSync,
  output logic                   VSync
);

  logic [NUM_TIMING-1:0][CNT_WIDTH-1:0] shadow_t, live_t;
  logic [3:0]                           shadow_ctrl, live_ctrl;

  logic                 en, hpol, vpol, test;
  logic [CNT_WIDTH-1:0] h_count, v_count;
  logic                 h_wrap, v_wrap, h_act, v_act, hs_on, vs_on;
  logic                 frame_end, commit, wr_acc, addr_hit;
  logic [DATA_WIDTH-1:0] pixel;

  assign en   = live_ctrl[CTRL_EN];
  assign hpol = live_ctrl[CTRL_HPOL];
  assign vpol = live_ctrl[CTRL_VPOL];
  assign test = live_ctrl[CTRL_TEST];

  // Only the frame-boundary copy stalls the bus; the continuous copy while
  // disabled must not, or the block could never be reprogrammed.
  assign frame_end = en && v_wrap;
  assign commit    = frame_end || !en;
  assign c_ready   = !frame_end;
  assign wr_acc    = c_valid && c_ready;
  assign addr_hit  = 32'(c_addr) < 32'(NUM_REGS);

  vga_axis_counter #(.CNT_WIDTH(CNT_WIDTH)) u_h (
    .clk(clk), .rst(rst), .en(en), .step(1'b1),
    .act(live_t[ADDR_H_ACT]), .fp(live_t[ADDR_H_FP]),
    .sync(live_t[ADDR_H_SYNC]), .bp(live_t[ADDR_H_BP]),
    .count(h_count), .wrap(h_wrap), .active(h_act), .sync_on(hs_on)
  );

  vga_axis_counter #(.CNT_WIDTH(CNT_WIDTH)) u_v (
    .clk(clk), .rst(rst), .en(en), .step(h_wrap),
    .act(live_t[ADDR_V_ACT]), .fp(live_t[ADDR_V_FP]),
    .sync(live_t[ADDR_V_SYNC]), .bp(live_t[ADDR_V_BP]),
    .count(v_count), .wrap(v_wrap), .active(v_act), .sync_on(vs_on)
  );

  assign pix_req = en && h_act && v_act;
  assign pix_x   = h_count;
  assign pix_y   = v_count;

  // Low nibble of a counter, truncated or zero-extended to a colour channel
  function automatic logic [COLOR_WIDTH-1:0] pat_chan(input logic [3:0] x);
    logic [COLOR_WIDTH+3:0] ext;
    ext = {{COLOR_WIDTH{1'b0}}, x};
    return ext[COLOR_WIDTH-1:0];
  endfunction

  // Pixel source: upstream data or the coordinate test pattern
  always_comb begin
    pixel = data_in;
    if (test) begin
      pixel[PIX_R*COLOR_WIDTH +: COLOR_WIDTH] = pat_chan(h_count[3:0]);
      pixel[PIX_G*COLOR_WIDTH +: COLOR_WIDTH] = pat_chan(v_count[3:0]);
      pixel[PIX_B*COLOR_WIDTH +: COLOR_WIDTH] = pat_chan(h_count[3:0] ^ v_count[3:0]);
    end
  end

  // Shadow registers and sticky unmapped-address flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TIMING; i++) shadow_t[i] <= CNT_WIDTH'(timing_default(i));
      shadow_ctrl <= 4'(DEF_CTRL);
      c_err       <= 1'b0;
    end else if (wr_acc) begin
      for (int i = 0; i < NUM_TIMING; i++)
        if (32'(c_addr) == 32'(i)) shadow_t[i] <= c_data;
      if (32'(c_addr) == 32'(ADDR_CTRL)) shadow_ctrl <= c_data[3:0];
      if (!addr_hit) c_err <= 1'b1;
    end
  end

  // Live registers: all fields copied from shadow in a single edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TIMING; i++) live_t[i] <= CNT_WIDTH'(timing_default(i));
      live_ctrl <= 4'(DEF_CTRL);
    end else if (commit) begin
      live_t    <= shadow_t;
      live_ctrl <= shadow_ctrl;
    end
  end

  // Pin outputs, one cycle behind the counter state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RED         <= '0;
      GREEN       <= '0;
      BLUE        <= '0;
      HSync       <= 1'b1;
      VSync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      RED         <= pix_req ? pixel[PIX_R*COLOR_WIDTH +: COLOR_WIDTH] : '0;
      GREEN       <= pix_req ? pixel[PIX_G*COLOR_WIDTH +: COLOR_WIDTH] : '0;
      BLUE        <= pix_req ? pixel[PIX_B*COLOR_WIDTH +: COLOR_WIDTH] : '0;
      HSync       <= en ? (hs_on ^ ~hpol) : ~hpol;
      VSync       <= en ? (vs_on ^ ~vpol) : ~vpol;
      frame_start <= en && (h_count == '0) && (v_count == '0);
    end
  end

endmodule
